// File: rtl/mult_timing_leak_monitor.sv
// Runs CHANNELS shift-add multipliers from one start pulse and reports first/last completion latency and skew.
// Latency: Lmax+1 cycles from accepted start to the timingLeakDone pulse; next start accepted at Lmax+2.
// Backpressure: none; start is ignored while busy. Optional macro MULT_TIMING_LEAK_EARLY_EXIT_EN enables data-dependent early exit.
module mult_timing_leak_monitor #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CHANNELS*WIDTH-1:0]  multiplier,
  input  logic [CHANNELS*WIDTH-1:0]  multiplicand,
  output logic [CHANNELS*2*WIDTH-1:0] product,
  output logic [CHANNELS-1:0]        doneMask,
  output logic                       busy,
  output logic [CNT_W-1:0]           firstLatency,
  output logic [CNT_W-1:0]           lastLatency,
  output logic [CNT_W-1:0]           skew,
  output logic                       timingLeak,
  output logic                       timingLeakDone
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t              state, stateNext;
  logic [CNT_W-1:0]    cnt;
  logic [2*WIDTH-1:0]  acc      [CHANNELS];
  logic [2*WIDTH-1:0]  accNext  [CHANNELS];
  logic [2*WIDTH-1:0]  capVal   [CHANNELS];
  logic [WIDTH:0]      sum      [CHANNELS];
  logic [WIDTH-1:0]    mcand    [CHANNELS];
  logic [CNT_W-1:0]    lat      [CHANNELS];
  logic [CHANNELS-1:0] strobe;
  logic [CHANNELS-1:0] doneReg;
  logic [CHANNELS-1:0] doneAll;
  logic [CNT_W-1:0]    firstVal;

`ifdef MULT_TIMING_LEAK_EARLY_EXIT_EN
  logic [CNT_W-1:0]    chanLat  [CHANNELS];

  // Latency of an early-exit channel: index of highest set multiplier bit plus one, minimum one.
  function automatic logic [CNT_W-1:0] lenOf(input logic [WIDTH-1:0] m);
    lenOf = CNT_W'(1);
    for (int b = 0; b < WIDTH; b++) begin
      if (m[b]) lenOf = CNT_W'(b + 1);
    end
  endfunction
`endif

  // One shift-add step per channel, its completion strobe and the value captured on completion.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]     = {1'b0, acc[i][2*WIDTH-1:WIDTH]} + (acc[i][0] ? {1'b0, mcand[i]} : '0);
      accNext[i] = {sum[i], acc[i][WIDTH-1:1]};
`ifdef MULT_TIMING_LEAK_EARLY_EXIT_EN
      lat[i]     = chanLat[i];
      // Remaining multiplier bits are zero, so finishing the shift here yields the exact product.
      capVal[i]  = accNext[i] >> (CNT_W'(WIDTH) - chanLat[i]);
`else
      lat[i]     = CNT_W'(WIDTH);
      capVal[i]  = accNext[i];
`endif
      strobe[i]  = (state == RUN) && (cnt == lat[i]);
    end
    doneAll  = doneReg | strobe;
    // Simultaneous first strobes all see an empty doneReg, so the first latency is taken once.
    firstVal = (doneReg == '0) ? cnt : firstLatency;
  end

  // Control FSM next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (&doneAll) stateNext = REPORT;
      REPORT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Datapath: operand load, iteration, completion capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      doneReg      <= '0;
      product      <= '0;
      firstLatency <= '0;
      lastLatency  <= '0;
      skew         <= '0;
      timingLeak   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]   <= '0;
        mcand[i] <= '0;
`ifdef MULT_TIMING_LEAK_EARLY_EXIT_EN
        chanLat[i] <= '0;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt          <= CNT_W'(1);
            doneReg      <= '0;
            product      <= '0;
            firstLatency <= '0;
            lastLatency  <= '0;
            skew         <= '0;
            timingLeak   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
              acc[i]   <= {{WIDTH{1'b0}}, multiplier[i*WIDTH +: WIDTH]};
              mcand[i] <= multiplicand[i*WIDTH +: WIDTH];
`ifdef MULT_TIMING_LEAK_EARLY_EXIT_EN
              chanLat[i] <= lenOf(multiplier[i*WIDTH +: WIDTH]);
`endif
            end
          end
        end
        RUN: begin
          cnt     <= (cnt == '1) ? cnt : cnt + 1'b1;
          doneReg <= doneAll;
          for (int i = 0; i < CHANNELS; i++) begin
            acc[i] <= accNext[i];
            if (strobe[i]) product[i*2*WIDTH +: 2*WIDTH] <= capVal[i];
          end
          if (|strobe && (doneReg == '0)) firstLatency <= cnt;
          if (&doneAll) begin
            lastLatency <= cnt;
            skew        <= cnt - firstVal;
            timingLeak  <= (cnt != firstVal);
          end
        end
        default: ;
      endcase
    end
  end

  // doneMask shows a channel as complete in its strobe cycle and holds it until the next start.
  assign doneMask       = doneAll;
  assign busy           = (state != IDLE);
  assign timingLeakDone = (state == REPORT);

endmodule

// File: tb/tb_mult_timing_leak_monitor.sv
module tb_mult_timing_leak_monitor;

  localparam int W  = 8;
  localparam int CW = 16;

`ifdef MULT_TIMING_LEAK_EARLY_EXIT_EN
  localparam int S1F = 2, S1S = 6, S2F = 1, S2S = 7, S3L = 5;
  localparam logic [1:0] DM2C1 = 2'b01;
`else
  localparam int S1F = 8, S1S = 0, S2F = 8, S2S = 0, S3L = 8;
  localparam logic [1:0] DM2C1 = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           start2 = 1'b0;
  logic [15:0]    mplier2 = '0, mcand2 = '0;
  logic [31:0]    product2;
  logic [1:0]     doneMask2;
  logic           busy2, leak2, ldone2;
  logic [CW-1:0]  first2, last2, skew2;

  logic           start4 = 1'b0;
  logic [31:0]    mplier4 = '0, mcand4 = '0;
  logic [63:0]    product4;
  logic [3:0]     doneMask4;
  logic           busy4, leak4, ldone4;
  logic [CW-1:0]  first4, last4, skew4;

  mult_timing_leak_monitor #(.WIDTH(W), .CHANNELS(2), .CNT_W(CW)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .multiplier(mplier2), .multiplicand(mcand2),
    .product(product2), .doneMask(doneMask2), .busy(busy2), .firstLatency(first2),
    .lastLatency(last2), .skew(skew2), .timingLeak(leak2), .timingLeakDone(ldone2));

  mult_timing_leak_monitor #(.WIDTH(W), .CHANNELS(4), .CNT_W(CW)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .multiplier(mplier4), .multiplicand(mcand4),
    .product(product4), .doneMask(doneMask4), .busy(busy4), .firstLatency(first4),
    .lastLatency(last4), .skew(skew4), .timingLeak(leak4), .timingLeakDone(ldone4));

  typedef struct {
    int          startCyc;
    int          first;
    int          last;
    int          skew;
    bit          leak;
    logic [63:0] prod;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  exp_t m2e, m4e;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor for the two-channel instance.
  always @(negedge clk) begin
    if (ldone2) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut2_unexpected_done actual=pulse required=none (cycle %0d)", cyc);
      end else begin
        m2e = q2.pop_front();
        check("dut2_done_cycle", 64'(cyc), 64'(m2e.startCyc + m2e.last + 1));
        check("dut2_first", 64'(first2), 64'(m2e.first));
        check("dut2_last", 64'(last2), 64'(m2e.last));
        check("dut2_skew", 64'(skew2), 64'(m2e.skew));
        check("dut2_leak", 64'(leak2), 64'(m2e.leak));
        check("dut2_product", {32'h0, product2}, m2e.prod);
        check("dut2_busy_report", 64'(busy2), 64'd1);
      end
    end
  end

  // Scoreboard monitor for the four-channel instance.
  always @(negedge clk) begin
    if (ldone4) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut4_unexpected_done actual=pulse required=none (cycle %0d)", cyc);
      end else begin
        m4e = q4.pop_front();
        check("dut4_done_cycle", 64'(cyc), 64'(m4e.startCyc + m4e.last + 1));
        check("dut4_first", 64'(first4), 64'(m4e.first));
        check("dut4_last", 64'(last4), 64'(m4e.last));
        check("dut4_skew", 64'(skew4), 64'(m4e.skew));
        check("dut4_leak", 64'(leak4), 64'(m4e.leak));
        check("dut4_product", product4, m4e.prod);
      end
    end
  end

  task automatic push2(input int sc, input int f, input int l, input int s, input bit lk, input logic [31:0] p);
    exp_t e;
    e.startCyc = sc; e.first = f; e.last = l; e.skew = s; e.leak = lk; e.prod = {32'h0, p};
    q2.push_back(e);
  endtask

  // Drives one start on dut2 in the next cycle (cycle 0); returns just after the accepting edge.
  task automatic go2(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1, input logic [7:0] b1,
                     input bit pushExp, input bit hold,
                     input int f, input int l, input int s, input bit lk, input logic [31:0] p);
    @(negedge clk);
    mplier2 = {a1, a0};
    mcand2  = {b1, b0};
    start2  = 1'b1;
    if (pushExp) push2(cyc, f, l, s, lk, p);
    @(posedge clk);
    #1;
    if (!hold) start2 = 1'b0;
  endtask

  task automatic waitIdle2();
    int n;
    n = 0;
    @(negedge clk);
    while (busy2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy2) begin
      checks++; failures++;
      $display("FAIL dut2_idle_timeout actual=busy required=idle (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e4;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_product", {32'h0, product2}, 64'h0);
    check("reset_doneMask", 64'(doneMask2), 64'h0);
    check("reset_busy", 64'(busy2), 64'h0);
    check("reset_latencies", {16'h0, first2, last2, skew2}, 64'h0);
    check("reset_flags", 64'({leak2, ldone2}), 64'h0);
    check("reset_dut4", {product4[31:0], 28'h0, doneMask4}, 64'h0);

    // Scenario 1: 0x03*0x05 and 0xFF*0xFF.
    go2(8'h03, 8'h05, 8'hFF, 8'hFF, 1'b1, 1'b0, S1F, 8, S1S, S1S != 0, {16'hFE01, 16'h000F});
    waitIdle2();

    // Scenario 2: multipliers 0x01 and 0x80, multiplicand 0x02.
    go2(8'h01, 8'h02, 8'h80, 8'h02, 1'b1, 1'b0, S2F, 8, S2S, S2S != 0, {16'h0100, 16'h0002});
    @(negedge clk);
    check("s2_doneMask_c1", 64'(doneMask2), 64'(DM2C1));
    repeat (6) @(negedge clk);
    check("s2_doneMask_c7", 64'(doneMask2), 64'(DM2C1));
    @(negedge clk);
    check("s2_doneMask_c8", 64'(doneMask2), 64'h3);
    waitIdle2();

    // Scenario 3: four channels, multiplier 0x10, multiplicand 0x0F.
    @(negedge clk);
    mplier4 = 32'h10101010;
    mcand4  = 32'h0F0F0F0F;
    start4  = 1'b1;
    e4.startCyc = cyc; e4.first = S3L; e4.last = S3L; e4.skew = 0; e4.leak = 1'b0;
    e4.prod = {16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0};
    q4.push_back(e4);
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (4) @(negedge clk);
    check("s3_doneMask_c4", 64'(doneMask4), 64'h0);
    repeat (S3L - 4) @(negedge clk);
    check("s3_doneMask_all", 64'(doneMask4), 64'hF);
    n = 0;
    while (busy4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("s3_idle", 64'(busy4), 64'h0);

    // Scenario 4: reset at cycle 4 of scenario 1, then a clean run.
    go2(8'h03, 8'h05, 8'hFF, 8'hFF, 1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy2), 64'h0);
    check("rst_mid_doneMask", 64'(doneMask2), 64'h0);
    check("rst_mid_product", {32'h0, product2}, 64'h0);
    check("rst_mid_results", {15'h0, leak2, first2, last2, skew2}, 64'h0);
    check("rst_mid_ldone", 64'(ldone2), 64'h0);
    repeat (12) @(negedge clk);
    check("rst_mid_still_idle", 64'(busy2), 64'h0);
    go2(8'h03, 8'h05, 8'hFF, 8'hFF, 1'b1, 1'b0, S1F, 8, S1S, S1S != 0, {16'hFE01, 16'h000F});
    waitIdle2();

    // Scenario 5: start held high through a run of scenario 1.
    go2(8'h03, 8'h05, 8'hFF, 8'hFF, 1'b1, 1'b1, S1F, 8, S1S, S1S != 0, {16'hFE01, 16'h000F});
    repeat (9) @(negedge clk);
    check("s5_busy_report", 64'(busy2), 64'h1);
    @(negedge clk);
    check("s5_idle_c10", 64'(busy2), 64'h0);
    check("s5_first_persist", 64'(first2), 64'(S1F));
    check("s5_product_persist", {32'h0, product2}, {32'h0, 16'hFE01, 16'h000F});
    check("s5_doneMask_persist", 64'(doneMask2), 64'h3);
    push2(cyc, S1F, 8, S1S, S1S != 0, {16'hFE01, 16'h000F});
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    check("s5_restart_busy", 64'(busy2), 64'h1);
    check("s5_restart_cleared", {15'h0, leak2, first2, last2, skew2}, 64'h0);
    check("s5_restart_product", {32'h0, product2}, 64'h0);
    check("s5_restart_doneMask", 64'(doneMask2), 64'h0);
    waitIdle2();

    repeat (3) @(negedge clk);
    check("q2_drained", 64'(q2.size()), 64'h0);
    check("q4_drained", 64'(q4.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_timing_leak_monitor.md
# mult_timing_leak_monitor

- Parametrised successor to the two-copy constant-time multiplier tester.
- Instantiates CHANNELS sequential shift-add multipliers, all started by one shared start pulse.
- Measures each channel's completion latency in cycles and reports the first/last latency and their skew.
- Raises timingLeak whenever the skew is non-zero.
- Sits in the constant-time verification harness, alongside the multiplier blocks it characterises.

## Interface
Parameters:
- WIDTH, 32: operand width per channel; must be 2 or more.
- CHANNELS, 2: number of multiplier copies; must be 2 or more.
- CNT_W, 16: width of the latency counter and latency outputs; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a measurement; accepted only while busy=0.
- multiplier  in  CHANNELS*WIDTH  flattened operands; channel i occupies bits [i*WIDTH +: WIDTH].
- multiplicand  in  CHANNELS*WIDTH  flattened, same packing as multiplier.
- product  out  CHANNELS*2*WIDTH  flattened products; channel i occupies bits [i*2*WIDTH +: 2*WIDTH].
- doneMask  out  CHANNELS  per-channel "has completed" flags for the current run.
- busy  out  1  high in RUN and REPORT.
- firstLatency  out  CNT_W  latency of the earliest-finishing channel.
- lastLatency  out  CNT_W  latency of the latest-finishing channel.
- skew  out  CNT_W  lastLatency - firstLatency.
- timingLeak  out  1  sticky; set when skew != 0.
- timingLeakDone  out  1  one-cycle pulse; all result outputs are valid in this cycle.

## Operation
- States are IDLE, RUN and REPORT.
- IDLE -> RUN: on the clk edge where start=1 in IDLE.
  - All channels load their operands.
  - The latency counter is set to 1.
  - doneMask, latency outputs, skew, timingLeak and product are cleared.
- RUN behaviour:
  - The counter increments each cycle and saturates at 2^CNT_W-1.
  - Each channel performs one shift-add iteration per cycle.
    - If the current multiplier LSB is 1, the multiplicand is added into the upper accumulator half.
    - The accumulator then shifts right.
  - A channel's done strobe is high in the RUN cycle whose counter value equals that channel's latency L.
  - In that cycle its doneMask bit is set and its product is captured.
- First completion: the first cycle with any strobe high stores the counter in firstLatency. Simultaneous strobes record it once.
- RUN -> REPORT: on the cycle in which doneMask becomes all-ones.
  - That cycle's counter is stored in lastLatency.
  - skew = lastLatency - firstLatency, computed as an unsigned CNT_W-bit value.
  - timingLeak = (skew != 0).
- REPORT -> IDLE: after one cycle.
  - timingLeakDone=1 during REPORT only.
  - Results hold until the next accepted start.
- start while busy=1, including in the REPORT cycle, is ignored with no side effect.
- Arithmetic: products are unsigned and exact, 2*WIDTH bits. There is no truncation.

## Timing
- Reset values: every output is 0, the state is IDLE, and the counter is 0.
- Reset mid-run: on the next edge, all channels abort and every output returns to 0. No timingLeakDone pulse is produced.
- Reset has priority over start in the same cycle.
- Constant-time channel: L = WIDTH regardless of operand values.
- Latency is counted from the start cycle (cycle 0).
  - Last done strobe: cycle Lmax.
  - timingLeakDone: cycle Lmax+1.
  - Earliest new start: cycle Lmax+2.
- doneMask bits rise individually and stay high until the next start.

## Configuration
- Macro: MULT_TIMING_LEAK_EARLY_EXIT_EN.
- Defined:
  - Each channel terminates early once its remaining unshifted multiplier bits are all zero.
  - L = bit index of the multiplier's highest set bit + 1, with a minimum of 1.
  - Examples: multiplier 0 or 1 gives L=1; 0x80 gives L=8.
  - The result is data-dependent timing. This is the deliberately leaky variant, used to prove the monitor detects leaks.
  - Products are still exact: the remaining shift is applied at capture.
- Undefined: every channel is constant-time with L = WIDTH. Early-exit logic is not synthesised.

## Test plan
1. Macro undefined, WIDTH=8, CHANNELS=2.
   - Stimulus: 0x03*0x05 and 0xFF*0xFF.
   - Required: both done strobes at cycle 8, firstLatency=lastLatency=8, skew=0, timingLeak=0.
   - Required: products 0x000F and 0xFE01; timingLeakDone at cycle 9.
2. Macro defined, WIDTH=8, CHANNELS=2.
   - Stimulus: multipliers 0x01 and 0x80, multiplicands 0x02 and 0x02.
   - Required: firstLatency=1, lastLatency=8, skew=7, timingLeak=1.
   - Required: products 0x0002 and 0x0100; doneMask=01 at cycle 1 and 11 at cycle 8.
3. Macro defined, CHANNELS=4.
   - Stimulus: all multipliers 0x10, multiplicand 0x0F.
   - Required: all strobes simultaneous at cycle 5, skew=0, timingLeak=0, every product 0x00F0.
4. Reset mid-run: assert rst at cycle 4 of scenario 1.
   - Required: next cycle, every output is 0 and busy=0; no timingLeakDone pulse.
   - Required: a subsequent start completes normally.
5. start held high through scenario 1.
   - Required: exactly one run, with a second run accepted only at cycle 10.
   - Required: start pulses in RUN/REPORT change nothing; results persist until the new start clears them.
